// File: rtl/muldiv_e.sv
// E-stage HI/LO multiply/divide unit with fixed-latency busy window.
// Optional MADD/MADDU accumulate support is enabled by defining MULDIV_MADD_EN.
module muldiv_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;
`endif

  logic [0:0]      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2*DW-1:0] pend, pend_nxt;
  logic [DW-1:0]   hi_nxt, lo_nxt;
  logic            busy_nxt;

  logic [2*DW-1:0] hilo, prod_s, prod_u;
  logic [DW-1:0]   abs_a, abs_b, div_s_b, div_u_b;
  logic [DW-1:0]   quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;

  assign hilo = {hi, lo};

  // Low 64 bits of a sign-extended product equal the signed product.
  assign prod_s = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
  assign prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

  // Signed divide via magnitudes; 0x80000000 is its own magnitude as unsigned.
  assign abs_a   = a[DW-1] ? (~a + DW'(1)) : a;
  assign abs_b   = b[DW-1] ? (~b + DW'(1)) : b;
  assign div_s_b = (b == '0) ? DW'(1) : abs_b;
  assign div_u_b = (b == '0) ? DW'(1) : b;
  assign quo_mag = abs_a / div_s_b;
  assign rem_mag = abs_a % div_s_b;
  assign quo_s   = (a[DW-1] ^ b[DW-1]) ? (~quo_mag + DW'(1)) : quo_mag;
  assign rem_s   = a[DW-1] ? (~rem_mag + DW'(1)) : rem_mag;
  assign quo_u   = a / div_u_b;
  assign rem_u   = a % div_u_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      busy  <= busy_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    busy_nxt  = busy;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_nxt  = (op == OP_MULT) ? prod_s : prod_u;
              cnt_nxt   = CW'(MULT_CYCLES);
              state_nxt = BUSY;
              busy_nxt  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero re-commits the current HI/LO, leaving them unchanged.
              if (b == '0)
                pend_nxt = hilo;
              else if (op == OP_DIV)
                pend_nxt = {rem_s, quo_s};
              else
                pend_nxt = {rem_u, quo_u};
              cnt_nxt   = CW'(DIV_CYCLES);
              state_nxt = BUSY;
              busy_nxt  = 1'b1;
            end
            OP_MTHI: hi_nxt = a;
            OP_MTLO: lo_nxt = a;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU: begin
              pend_nxt  = hilo + ((op == OP_MADD) ? prod_s : prod_u);
              cnt_nxt   = CW'(MULT_CYCLES);
              state_nxt = BUSY;
              busy_nxt  = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          {hi_nxt, lo_nxt} = pend;
          cnt_nxt   = '0;
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_muldiv_e.sv
// Directed self-checking bench for muldiv_e: vector table plus hand-written
// sequences for back-to-back moves, start-while-busy and asynchronous reset.
module tb_muldiv_e;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
  localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, MADD = 3'b110, MADDU = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  muldiv_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] o, input logic [31:0] va,
                              input logic [31:0] vb, input int c, input logic [31:0] eh,
                              input logic [31:0] el);
    vec_t v;
    v.name = name; v.op = o; v.a = va; v.b = vb; v.cyc = c; v.hi = eh; v.lo = el;
    return v;
  endfunction

  // One-edge start pulse, then count busy cycles (bounded) and check HI/LO.
  task automatic run_op(input vec_t v);
    int n;
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = MULTU;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({v.name, ".cycles"}, 32'(n), 32'(v.cyc));
    chk({v.name, ".hi"}, hi, v.hi);
    chk({v.name, ".lo"}, lo, v.lo);
  endtask

  initial begin
    int n;
    int hits;

    vecs.push_back(mk("mult_neg",  MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA));
    vecs.push_back(mk("multu",     MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA));
    vecs.push_back(mk("div_neg",   DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
    vecs.push_back(mk("divu",      DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3));
    vecs.push_back(mk("mthi",      MTHI,  32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'd3));
    vecs.push_back(mk("mtlo",      MTLO,  32'h9ABC_DEF0, 32'd0, 0, 32'h1234_5678, 32'h9ABC_DEF0));
    vecs.push_back(mk("pre_hi",    MTHI,  32'h11, 32'd0, 0, 32'h11, 32'h9ABC_DEF0));
    vecs.push_back(mk("pre_lo",    MTLO,  32'h22, 32'd0, 0, 32'h11, 32'h22));
    vecs.push_back(mk("div_zero",  DIV,   32'd5, 32'd0, 10, 32'h11, 32'h22));
    vecs.push_back(mk("divu_zero", DIVU,  32'd9, 32'd0, 10, 32'h11, 32'h22));
    vecs.push_back(mk("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000));
    vecs.push_back(mk("mult_max",  MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 32'h3FFF_FFFF, 32'h1));
    vecs.push_back(mk("div_negb",  DIV,   32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD));
    vecs.push_back(mk("divu_big",  DIVU,  32'hFFFF_FFFF, 32'd16, 10, 32'hF, 32'h0FFF_FFFF));
    vecs.push_back(mk("madd_hi0",  MTHI,  32'h0, 32'd0, 0, 32'h0, 32'h0FFF_FFFF));
    vecs.push_back(mk("madd_lo",   MTLO,  32'hFFFF_FFFF, 32'd0, 0, 32'h0, 32'hFFFF_FFFF));
`ifdef MULDIV_MADD_EN
    vecs.push_back(mk("maddu",     MADDU, 32'd1, 32'd1, 5, 32'h1, 32'h0));
    vecs.push_back(mk("madd_neg",  MADD,  32'hFFFF_FFFF, 32'd1, 5, 32'h0, 32'hFFFF_FFFF));
`else
    vecs.push_back(mk("maddu_off", MADDU, 32'd1, 32'd1, 0, 32'h0, 32'hFFFF_FFFF));
    vecs.push_back(mk("madd_off",  MADD,  32'hFFFF_FFFF, 32'd1, 0, 32'h0, 32'hFFFF_FFFF));
`endif

    // Reset state
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Back-to-back MTHI then MTLO on consecutive edges, busy never high
    hits = 0;
    @(negedge clk);
    start = 1'b1; op = MTHI; a = 32'h1234_5678;
    @(negedge clk);
    hits += int'(busy);
    op = MTLO; a = 32'h9ABC_DEF0;
    @(negedge clk);
    hits += int'(busy);
    start = 1'b0;
    @(negedge clk);
    hits += int'(busy);
    chk("b2b.busy_seen", 32'(hits), 32'd0);
    chk("b2b.hi", hi, 32'h1234_5678);
    chk("b2b.lo", lo, 32'h9ABC_DEF0);

    // Start during BUSY is ignored
    @(negedge clk);
    start = 1'b1; op = MULT; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 2) begin
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_start.cycles", 32'(n), 32'd5);
    chk("busy_start.hi", hi, 32'd0);
    chk("busy_start.lo", lo, 32'd6);
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      hits += int'(busy);
    end
    chk("busy_start.no_retrigger", 32'(hits), 32'd0);
    chk("busy_start.lo_kept", lo, 32'd6);

    // Asynchronous reset three edges into a MULT
    run_op(mk("pre_hi2", MTHI, 32'h55, 32'd0, 0, 32'h55, 32'd6));
    @(negedge clk);
    start = 1'b1; op = MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset.busy", 32'(busy), 32'd0);
    chk("areset.hi", hi, 32'd0);
    chk("areset.lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      hits += int'(busy);
    end
    chk("areset.busy_after", 32'(hits), 32'd0);
    chk("areset.hi_after", hi, 32'd0);
    chk("areset.lo_after", lo, 32'd0);

    // First start after reset release is accepted
    run_op(mk("post_reset", MULTU, 32'h10, 32'h10, 5, 32'h0, 32'h100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
